mux8_rr_arbiter: RTL
====================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 8:1 single-bit mux datapath among 8 requesters.
//  Grants the mux to one requester at a time and drives the mux select lines so
//  that the granted requester's input is routed to the shared output.
//  Sits directly upstream of the 8:1 mux; sel[2:0] maps to mux select {S0,S1,S2}
//  (S0 = MSB).
// PARAMETERS
//  MAX_HOLD  16  max consecutive grant cycles per owner; used only with ARB_TIMEOUT_EN; legal 2..255
// PORTS
//  clk      in   1  single clock; all logic on posedge clk
//  rst      in   1  synchronous, active-high reset
//  req      in   8  request vector; req[i] = requester i wants the mux
//  done     in   1  owner finished; releases grant (sampled only while busy)
//  grant    out  8  one-hot grant; all-zero when idle
//  sel      out  3  mux select = index of granted requester; sel[2]->S0, sel[1]->S1, sel[0]->S2
//  busy     out  1  1 while a grant is held
//  timeout  out  1  1-cycle pulse on forced release (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  - All outputs registered. Reset (rst=1 at posedge): grant=0, sel=0, busy=0,
//    timeout=0, ptr=0, hold counter=0, state=IDLE.
//  - rst mid-grant clears the grant at that edge; no release handshake.
//  - ptr[2:0] = round-robin start index. Winner = first set req bit searching
//    ptr, ptr+1, ..., ptr+7 (mod 8). Each grant sets ptr = winner+1 (mod 8; 7 wraps to 0).
//  - FSM states:
//    IDLE:  if |req, grant winner at next edge -> GRANT
//           (1-cycle latency req->grant); else stay.
//    GRANT: owner = granted index. Release when done=1, or req[owner]=0, or
//           forced timeout. Both done and req drop in the same cycle = one release.
//           No release -> hold grant/sel unchanged.
//           On release edge: if |req (same-cycle sample), grant new winner at that
//           same edge (back-to-back, no idle cycle); else -> IDLE with grant=0, busy=0.
//  - ptr already equals owner+1 at release, so a releasing owner still requesting
//    has lowest priority. If it is the sole requester it is re-granted immediately.
//  - done is ignored in IDLE.
//  - sel is only meaningful while busy=1; holds 0 when idle.
//  - grant is always one-hot or zero; never two bits set.
//  - grant, sel and busy change only on a clock edge; never mid-cycle.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//    - 8-bit hold counter resets to 0 on every new grant and increments each GRANT cycle.
//    - On the MAX_HOLD-th consecutive grant cycle, release is forced and
//      timeout=1 for exactly 1 cycle.
//    - Re-arbitration then follows the normal release rule.
//    - A voluntary release in the same cycle still counts as a timeout (timeout=1).
//  ARB_TIMEOUT_EN undefined:
//    - No counter; an owner may hold indefinitely.
//    - timeout is tied to 0.
//    - MAX_HOLD is unused.
// TESTING
//  1. rst=1 for 2 cycles with req=8'hFF -> grant=0, sel=0, busy=0, timeout=0 throughout.
//  2. From reset, req=8'h08 at cycle t -> grant=8'h08, sel=3'd3, busy=1 at t+1.
//     Pulse done -> busy=0, grant=0 next cycle.
//  3. req=8'hFF held, done pulsed every 3rd cycle -> grants 0,1,2,...,7,0 in order,
//     back-to-back with no idle cycle; sel tracks grant index.
//  4. Owner 5 granted, req=8'h21, drop req[5] -> next edge grant=8'h01, sel=0.
//     Then done with req[0] still the sole request -> owner 0 re-granted.
//  5. With ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h06, no done:
//     grant 8'h02 for 4 cycles, timeout pulse, then 8'h04 for 4 cycles, then 8'h02.
//     Without the macro: 8'h02 held for 100 cycles and timeout=0 throughout.
//  6. rst asserted while owner 6 holds grant -> next edge grant=0, busy=0, ptr=0.
//     After rst drops with req=8'h41, owner 0 is granted first.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 8:1 single-bit mux.
// Optional forced release after MAX_HOLD grant cycles is enabled by ARB_TIMEOUT_EN.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be within 2..255");
  end

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] ptr_r;
  logic [2:0] ptr_s;
  logic [7:0] grant_s;
  logic [2:0] sel_s;
  logic       busy_s;
  logic [2:0] winner_s;
  logic       release_s;
  logic       force_s;
  logic       new_grant_s;

  // First requester found when scanning upward from the round-robin pointer.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  assign winner_s  = rr_pick(req, ptr_r);
  // sel holds the owner index while busy, so it doubles as the owner register.
  assign release_s = done | ~req[sel] | force_s;

  // Next-state, grant and pointer selection.
  always_comb begin
    next_state_s = state_r;
    grant_s      = grant;
    sel_s        = sel;
    busy_s       = busy;
    ptr_s        = ptr_r;
    new_grant_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          next_state_s = GRANT;
          grant_s      = 8'b1 << winner_s;
          sel_s        = winner_s;
          busy_s       = 1'b1;
          ptr_s        = winner_s + 3'd1;
          new_grant_s  = 1'b1;
        end else begin
          grant_s = 8'h00;
          sel_s   = 3'd0;
          busy_s  = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          if (|req) begin
            next_state_s = GRANT;
            grant_s      = 8'b1 << winner_s;
            sel_s        = winner_s;
            busy_s       = 1'b1;
            ptr_s        = winner_s + 3'd1;
            new_grant_s  = 1'b1;
          end else begin
            next_state_s = IDLE;
            grant_s      = 8'h00;
            sel_s        = 3'd0;
            busy_s       = 1'b0;
          end
        end else begin
          next_state_s = GRANT;
        end
      end
      default: begin
        next_state_s = IDLE;
        grant_s      = 8'h00;
        sel_s        = 3'd0;
        busy_s       = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      grant   <= 8'h00;
      sel     <= 3'd0;
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ptr_r   <= ptr_s;
      grant   <= grant_s;
      sel     <= sel_s;
      busy    <= busy_s;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_r;

  // Counter value equals the number of completed cycles of the current grant.
  assign force_s = (state_r == GRANT) && (hold_cnt_r == HOLD_LAST);

  // Hold counter restarts on every grant, including an immediate re-grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r <= 8'd0;
    end else if (new_grant_s) begin
      hold_cnt_r <= 8'd0;
    end else if (state_r == GRANT) begin
      hold_cnt_r <= hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // One-cycle pulse following a forced release.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= force_s;
    end
  end
`else
  assign force_s = 1'b0;

  // Without the hold limit the pulse can never fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
    end
  end
`endif

endmodule
